// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite to RAM bridge: response codes,
// bridge FSM states and arbitration grant tags.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WRESP,
    ST_RREQ,
    ST_RRESP
  } bridge_state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

endpackage

// File: rtl/axil_ram_bridge.sv
// AXI4-Lite slave that serialises reads and writes into single-cycle RAM
// requests, word-aligning and range-checking each address.
module axil_ram_bridge
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0800_0000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    ram_valid,
  output logic                    ram_wen,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_wmask,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  // Window bounds carry one extra bit so a window ending at the top of the
  // address space cannot wrap.
  localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_WIDTH:0] RANGE_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE}
                                           - {{(ADDR_WIDTH-2){1'b0}}, 3'b100};

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= RANGE_LO) && ({1'b0, a} <= RANGE_HI);
  endfunction

  bridge_state_t           state, state_nxt;
  grant_t                  last_grant;
  logic                    aw_full, w_full;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic                    write_ready, read_ready;
  logic                    grant_write, grant_read;
  logic                    in_range;

  assign write_ready = aw_full & w_full;
  assign read_ready  = arvalid;
  assign grant_write = (state == ST_IDLE) && write_ready &&
                       (!read_ready || (last_grant == GRANT_READ));
  assign grant_read  = (state == ST_IDLE) && read_ready && !grant_write;
  assign in_range    = in_window(ram_addr);

  // Ready outputs are held low while reset is asserted.
  assign awready = reset_n && !aw_full;
  assign wready  = reset_n && !w_full;
  assign arready = reset_n && grant_read;

  always_comb begin
    state_nxt = state;
    ram_valid = 1'b0;
    ram_wen   = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_write)     state_nxt = ST_WREQ;
        else if (grant_read) state_nxt = ST_RREQ;
      end
      ST_WREQ: begin
        ram_valid = in_range;
        ram_wen   = in_range;
        state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = ST_IDLE;
      end
      ST_RREQ: begin
        ram_valid = in_range;
        state_nxt = ST_RRESP;
      end
      ST_RRESP: begin
        rvalid = 1'b1;
        if (rready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_READ;
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      bresp      <= RESP_OKAY;
      rresp      <= RESP_OKAY;
      rdata      <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wmask  <= '0;
    end else begin
      state <= state_nxt;

      // Both flags are full when a write is granted, so no handshake can race the clear.
      if (grant_write) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_full <= 1'b1;
        if (wvalid && wready)   w_full  <= 1'b1;
      end

      if (state == ST_WRESP && bready) last_grant <= GRANT_WRITE;
      if (state == ST_RRESP && rready) last_grant <= GRANT_READ;

      if (grant_write) begin
        ram_addr  <= word_align(aw_addr_q);
        ram_wdata <= w_data_q;
        ram_wmask <= w_strb_q;
      end else if (grant_read) begin
        ram_addr  <= word_align(araddr);
      end

      if (state == ST_WREQ) bresp <= in_range ? RESP_OKAY : RESP_SLVERR;

      if (state == ST_RREQ) begin
        rdata <= in_range ? ram_rdata : '0;
        rresp <= in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (awvalid && awready) aw_addr_q <= awaddr;
    if (wvalid && wready) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

endmodule

// File: tb/tb_axil_ram_bridge.sv
// Directed bench for axil_ram_bridge: table-driven reads and writes against a
// small byte-masked RAM model, plus arbitration, backpressure and reset sequences.
module tb_axil_ram_bridge;
  import axil_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  wstrb, ram_wmask;
  logic [1:0]  bresp, rresp;
  logic        ram_valid, ram_wen;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  axil_ram_bridge dut (
    .clock(clock), .reset_n(reset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ram_valid(ram_valid), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  // RAM model: 64 words, word i preset to 0xA500_00ii, aliased over the address space.
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;
  int          ram_valid_cnt = 0;
  int          rvalid_cnt = 0;
  int          wen_viol = 0;
  logic [31:0] last_addr = '0;
  logic        last_wen = 1'b0;
  logic [3:0]  last_mask = '0;
  logic [7:0]  wen_log = '0;

  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (ram_valid && ram_wen) begin
      for (int b = 0; b < 4; b++)
        if (ram_wmask[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    if (ram_valid) begin
      ram_valid_cnt <= ram_valid_cnt + 1;
      last_addr     <= ram_addr;
      last_wen      <= ram_wen;
      last_mask     <= ram_wmask;
      wen_log       <= {wen_log[6:0], ram_wen};
    end
    if (rvalid) rvalid_cnt <= rvalid_cnt + 1;
  end

  always @(negedge clock) if (!ram_valid && ram_wen) wen_viol <= wen_viol + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_txn(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output int nv);
    int t;
    int start;
    @(negedge clock);
    arvalid = 1'b1;
    araddr  = a;
    t = 0;
    while (!arready && t < 50) begin @(negedge clock); t++; end
    start = ram_valid_cnt;
    lat = 0;
    do begin @(negedge clock); arvalid = 1'b0; lat++; end while (!rvalid && lat < 50);
    d    = rdata;
    resp = rresp;
    @(negedge clock);
    nv = ram_valid_cnt - start;
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp, output int lat, output int nv);
    int start;
    start = ram_valid_cnt;
    @(negedge clock);
    wvalid = 1'b1; wdata = d; wstrb = s;
    if (lead == 0) begin awvalid = 1'b1; awaddr = a; end
    @(negedge clock);
    wvalid = 1'b0;
    if (lead > 0) begin
      repeat (lead - 1) @(negedge clock);
      awvalid = 1'b1; awaddr = a;
      @(negedge clock);
    end
    awvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin @(negedge clock); lat++; end
    resp = bresp;
    @(negedge clock);
    nv = ram_valid_cnt - start;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_nv;
  } rd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    logic [1:0]  exp_resp;
    int          exp_nv;
    logic [31:0] exp_rb;
  } wr_vec_t;

  rd_vec_t rv[6];
  wr_vec_t wv[3];

  initial begin
    logic [31:0] d, hold;
    logic [1:0]  resp;
    int          lat, nv, t, start;
    logic        stable, aw_f, w_f, ar_f;
    logic [31:0] got_rd;

    rv[0] = '{32'h8000_0004, 32'hA500_0001, RESP_OKAY,   1};
    rv[1] = '{32'h7FFF_FFFC, 32'h0000_0000, RESP_SLVERR, 0};
    rv[2] = '{32'h8800_0000, 32'h0000_0000, RESP_SLVERR, 0};
    rv[3] = '{32'h87FF_FFFC, 32'hA500_003F, RESP_OKAY,   1};
    rv[4] = '{32'h8000_0009, 32'hA500_0002, RESP_OKAY,   1};
    rv[5] = '{32'hFFFF_FFFC, 32'h0000_0000, RESP_SLVERR, 0};

    wv[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 3, RESP_OKAY,   1, 32'hA500_BEEF};
    wv[1] = '{32'h9000_0000, 32'hCAFE_F00D, 4'b1111, 0, RESP_SLVERR, 0, 32'h0000_0000};
    wv[2] = '{32'h8000_0016, 32'h1234_5678, 4'b0000, 0, RESP_OKAY,   1, 32'hA500_0005};

    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_handshake", 32'({awready, wready, arready, bvalid, rvalid, ram_valid, ram_wen}), 32'h0);
    chk("rst_resp", 32'({bresp, rresp}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata_mask", ram_wdata | 32'(ram_wmask), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", 32'({awready, wready}), 32'h3);

    // Table-driven reads
    for (int i = 0; i < 6; i++) begin
      start = ram_valid_cnt;
      read_txn(rv[i].addr, d, resp, lat, nv);
      chk($sformatf("rd%0d_data", i), d, rv[i].exp_data);
      chk($sformatf("rd%0d_resp", i), 32'(resp), 32'(rv[i].exp_resp));
      chk($sformatf("rd%0d_latency", i), lat, 2);
      chk($sformatf("rd%0d_ram_cnt", i), nv, rv[i].exp_nv);
      if (rv[i].exp_nv == 1) begin
        chk($sformatf("rd%0d_ram_addr", i), last_addr, rv[i].addr & 32'hFFFF_FFFC);
        chk($sformatf("rd%0d_ram_wen", i), 32'(last_wen), 32'h0);
      end
    end

    // Table-driven writes with readback
    for (int i = 0; i < 3; i++) begin
      write_txn(wv[i].addr, wv[i].data, wv[i].strb, wv[i].lead, resp, lat, nv);
      chk($sformatf("wr%0d_bresp", i), 32'(resp), 32'(wv[i].exp_resp));
      chk($sformatf("wr%0d_latency", i), lat, 2);
      chk($sformatf("wr%0d_ram_cnt", i), nv, wv[i].exp_nv);
      if (wv[i].exp_nv == 1) begin
        chk($sformatf("wr%0d_ram_addr", i), last_addr, wv[i].addr & 32'hFFFF_FFFC);
        chk($sformatf("wr%0d_ram_mask", i), 32'(last_mask), 32'(wv[i].strb));
        chk($sformatf("wr%0d_ram_wen", i), 32'(last_wen), 32'h1);
      end
      read_txn(wv[i].addr, d, resp, lat, nv);
      chk($sformatf("wr%0d_readback", i), d, wv[i].exp_rb);
    end

    // Arbitration after a fresh reset: write, read, write
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    start = ram_valid_cnt;
    awvalid = 1; awaddr = 32'h8000_0020; wvalid = 1; wdata = 32'h1122_3344; wstrb = 4'hF;
    @(negedge clock);
    awaddr = 32'h8000_0024; wdata = 32'h5566_7788;
    arvalid = 1; araddr = 32'h8000_0020;
    chk("arb_first_arready", 32'(arready), 32'h0);
    got_rd = '0;
    for (int c = 0; c < 30; c++) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      ar_f = arvalid && arready;
      @(negedge clock);
      if (aw_f) awvalid = 0;
      if (w_f)  wvalid = 0;
      if (ar_f) arvalid = 0;
      if (rvalid) got_rd = rdata;
    end
    chk("arb_ram_cnt", ram_valid_cnt - start, 3);
    chk("arb_order", 32'(wen_log[2:0]), 32'b101);
    chk("arb_read_data", got_rd, 32'h1122_3344);
    read_txn(32'h8000_0024, d, resp, lat, nv);
    chk("arb_second_write", d, 32'h5566_7788);

    // Read response backpressure
    @(negedge clock);
    rready = 0; arvalid = 1; araddr = 32'h8000_0008;
    t = 0;
    while (!arready && t < 50) begin @(negedge clock); t++; end
    @(negedge clock);
    araddr = 32'h8000_000C;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clock); t++; end
    hold = rdata; start = ram_valid_cnt; stable = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (!rvalid || rdata !== hold || arready) stable = 1'b0;
    end
    chk("bp_data", hold, 32'hA500_0002);
    chk("bp_stable", 32'(stable), 32'h1);
    chk("bp_no_ram", ram_valid_cnt - start, 0);
    rready = 1;
    @(negedge clock);
    chk("bp_next_arready", 32'(arready), 32'h1);
    @(negedge clock);
    arvalid = 0;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clock); t++; end
    chk("bp_next_data", rdata, 32'hA500_0003);
    @(negedge clock);

    // Reset pulsed during RREQ
    @(negedge clock);
    arvalid = 1; araddr = 32'h8000_0004;
    @(negedge clock);
    arvalid = 0;
    chk("rr_ram_valid_pre", 32'(ram_valid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rr_handshake", 32'({awready, wready, arready, bvalid, rvalid, ram_valid, ram_wen}), 32'h0);
    chk("rr_ram_addr", ram_addr, 32'h0);
    chk("rr_rdata", rdata, 32'h0);
    chk("rr_ram_wdata", ram_wdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    start = rvalid_cnt;
    repeat (6) @(negedge clock);
    chk("rr_no_rvalid", rvalid_cnt - start, 0);
    read_txn(32'h8000_0004, d, resp, lat, nv);
    chk("rr_recover_data", d, 32'hA500_0001);

    chk("wen_without_valid", wen_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
